axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command stream (address, write flag, data) into AXI4-Lite read or write transactions and returns the response on a valid/ready response stream. It sits between a command source (test sequencer, debug bridge, or small controller) and any AXI4-Lite responder in the design, such as the UART register block. It is the requesting end of the same 32-bit AXI4-Lite interface the UART responder exposes.

## Interface
- AXI_ADDR_BW_p, 12, address width of command and AXI address channels
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- i_cmd_valid  input  1  command present
- o_cmd_ready  output  1  command accepted this cycle when both high
- i_cmd_write  input  1  1 = write, 0 = read
- i_cmd_addr  input  AXI_ADDR_BW_p  byte address, passed unmodified to AWADDR/ARADDR
- i_cmd_wdata  input  32  write data (ignored for reads)
- o_rsp_valid  output  1  response present
- i_rsp_ready  input  1  response consumed when both high
- o_rsp_write  output  1  response belongs to a write
- o_rsp_resp  output  2  captured BRESP/RRESP
- o_rsp_rdata  output  32  captured RDATA; 0 for writes
- o_axi_awaddr/o_axi_awvalid, i_axi_awready; o_axi_wdata(32)/o_axi_wvalid, i_axi_wready; i_axi_bresp(2)/i_axi_bvalid, o_axi_bready; o_axi_araddr/o_axi_arvalid, i_axi_arready; i_axi_rdata(32)/i_axi_rresp(2)/i_axi_rvalid, o_axi_rready — standard AXI4-Lite initiator channels, widths as named

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: o_cmd_ready=1 (combinational from state only). On i_cmd_valid: latch addr/data/write flag; go WR_REQ (awvalid=1, wvalid=1) or RD_REQ (arvalid=1).
- WR_REQ: AW and W complete independently; each valid drops the cycle after its own handshake and never re-asserts. When both are done (including both in the same cycle) → WR_RESP.
- WR_RESP: o_axi_bready=1; on bvalid capture bresp, rdata=0, write=1 → RSP.
- RD_REQ: arvalid held until arready → RD_RESP.
- RD_RESP: o_axi_rready=1; on rvalid capture rdata/rresp, write=0 → RSP.
- RSP: o_rsp_valid=1, outputs stable until i_rsp_ready; then → IDLE.
- bready/rready are only high in their RESP states; early bvalid/rvalid is held off by the responder.
- Address/data/valid outputs are registered and stable while valid is high (AXI rule: no retraction, no change).
- SLVERR/DECERR are reported, not retried.

## Timing
- Reset values: all valid/ready outputs 0 except o_cmd_ready=1; addr/data/rsp outputs 0; FSM IDLE.
- Reset mid-transaction: all outputs return to reset values immediately; the in-flight transfer is abandoned (the responder must share the reset).
- Cycle 0 command accept → cycle 1 AW/W or AR valid.
- Zero-wait responder: write response valid on o_rsp_valid at cycle 3, read at cycle 3; o_cmd_ready again the cycle after the rsp handshake.
- Throughput: at most one transaction every 4 cycles; no pipelining, no ID reordering.

## Structure
- Shared package axi_lite_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit constants, FSM state enum typedef; the UART responder should import the same constants.
- Single module, no sub-modules; the FSM, the AW-done/W-done flags and the response capture registers are all local.

## Test plan
- Write 0x08 ← 0x0000_0E83 to the UART responder with zero wait states → AW/W at cycle 1, rsp_valid at cycle 3, rsp_resp=00, write=1; read back of 0x08 returns 0x0000_0E83.
- awready delayed 3 cycles, wready immediate → wvalid drops after cycle 1, awvalid held with a stable address until its handshake; bready only asserted afterwards.
- Read from 0x1C (unmapped) → rsp_resp=10, rdata=0xDEADDEAD.
- Hold i_rsp_ready=0 for 5 cycles → o_rsp_* stable, o_cmd_ready=0, no new AXI valids.
- Back-to-back commands with i_cmd_valid held high → second command accepted exactly one cycle after the first rsp handshake.
- Assert rst_n=0 during WR_REQ → all valids drop without waiting for a clock; o_cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the
// initiator FSM state type shared by master and responders.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    RSP
  } state_e;

endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator
// turning a valid/ready command stream into AXI4-Lite transfers.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_BW_p = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [AXI_ADDR_BW_p-1:0] i_cmd_addr,
  input  logic [31:0]              i_cmd_wdata,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_write,
  output logic [1:0]               o_rsp_resp,
  output logic [31:0]              o_rsp_rdata,
  output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [31:0]              o_axi_wdata,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  input  logic [1:0]               i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready,
  output logic [AXI_ADDR_BW_p-1:0] o_axi_araddr,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  input  logic [31:0]              i_axi_rdata,
  input  logic [1:0]               i_axi_rresp,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready
);

  state_e state_q, state_d;

  logic [AXI_ADDR_BW_p-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic                     awvalid_q;
  logic                     wvalid_q;
  logic                     arvalid_q;
  logic                     rsp_write_q;
  logic [1:0]               rsp_resp_q;
  logic [31:0]              rsp_rdata_q;
  logic                     cmd_fire;
  logic                     aw_done;
  logic                     w_done;

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_axi_bready = (state_q == WR_RESP);
  assign o_axi_rready = (state_q == RD_RESP);
  assign o_rsp_valid  = (state_q == RSP);

  assign o_axi_awaddr  = addr_q;
  assign o_axi_araddr  = addr_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_awvalid = awvalid_q;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_rsp_write   = rsp_write_q;
  assign o_rsp_resp    = rsp_resp_q;
  assign o_rsp_rdata   = rsp_rdata_q;

  assign cmd_fire = o_cmd_ready & i_cmd_valid;
  // a channel is done once its valid has dropped or it handshakes now
  assign aw_done  = ~awvalid_q | i_axi_awready;
  assign w_done   = ~wvalid_q | i_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          state_d = i_cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_done && w_done) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (i_axi_bvalid) state_d = RSP;
      end
      RD_REQ: begin
        if (i_axi_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (i_axi_rvalid) state_d = RSP;
      end
      RSP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= i_cmd_addr;
        wdata_q   <= i_cmd_wdata;
        awvalid_q <= i_cmd_write;
        wvalid_q  <= i_cmd_write;
        arvalid_q <= ~i_cmd_write;
      end
      if (awvalid_q && i_axi_awready) awvalid_q <= 1'b0;
      if (wvalid_q && i_axi_wready)   wvalid_q  <= 1'b0;
      if (arvalid_q && i_axi_arready) arvalid_q <= 1'b0;
      if (o_axi_bready && i_axi_bvalid) begin
        rsp_write_q <= 1'b1;
        rsp_resp_q  <= i_axi_bresp;
        rsp_rdata_q <= '0;
      end
      if (o_axi_rready && i_axi_rvalid) begin
        rsp_write_q <= 1'b0;
        rsp_resp_q  <= i_axi_rresp;
        rsp_rdata_q <= i_axi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed and random transactions against
// a behavioural register-block responder and a transaction model.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_write = 1'b0;
  logic [11:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic        o_rsp_write;
  logic [1:0]  o_rsp_resp;
  logic [31:0] o_rsp_rdata;
  logic [11:0] o_axi_awaddr;
  logic        o_axi_awvalid;
  logic        i_axi_awready = 1'b0;
  logic [31:0] o_axi_wdata;
  logic        o_axi_wvalid;
  logic        i_axi_wready = 1'b0;
  logic [1:0]  i_axi_bresp = '0;
  logic        i_axi_bvalid = 1'b0;
  logic        o_axi_bready;
  logic [11:0] o_axi_araddr;
  logic        o_axi_arvalid;
  logic        i_axi_arready = 1'b0;
  logic [31:0] i_axi_rdata = '0;
  logic [1:0]  i_axi_rresp = '0;
  logic        i_axi_rvalid = 1'b0;
  logic        o_axi_rready;

  always #5 clk = ~clk;

  axi_lite_master #(.AXI_ADDR_BW_p(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write), .i_cmd_addr(i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_write(o_rsp_write), .o_rsp_resp(o_rsp_resp),
    .o_rsp_rdata(o_rsp_rdata),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awvalid(o_axi_awvalid),
    .i_axi_awready(i_axi_awready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wvalid(o_axi_wvalid),
    .i_axi_wready(i_axi_wready),
    .i_axi_bresp(i_axi_bresp), .i_axi_bvalid(i_axi_bvalid),
    .o_axi_bready(o_axi_bready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arvalid(o_axi_arvalid),
    .i_axi_arready(i_axi_arready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // register block: words 0x00..0x18 mapped, the rest SLVERR
  function automatic bit mapped(input logic [11:0] a);
    return (a[11:5] == 0) && (a[1:0] == 0) && (a[4:2] != 3'd7);
  endfunction

  // ---------------- behavioural responder ----------------
  logic [31:0] slave_mem [8];
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_got, w_got, ar_got;
  bit aw_fp, w_fp, ar_fp, b_fp, r_fp;
  logic [11:0] aw_a, ar_a;
  logic [31:0] w_d;

  task automatic resp_clear();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    aw_fp = 0; w_fp = 0; ar_fp = 0; b_fp = 0; r_fp = 0;
    i_axi_awready = 0; i_axi_wready = 0; i_axi_arready = 0;
    i_axi_bvalid = 0; i_axi_rvalid = 0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) slave_mem[k] = '0;
    resp_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        resp_clear();
      end else begin
        if (aw_fp) aw_got = 1;
        if (w_fp) w_got = 1;
        if (ar_fp) ar_got = 1;
        if (b_fp) begin
          i_axi_bvalid = 0; aw_got = 0; w_got = 0;
          aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end
        if (r_fp) begin
          i_axi_rvalid = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
          i_axi_rdata = $urandom;
        end
        i_axi_awready = 0;
        if (o_axi_awvalid && !aw_got) begin
          if (aw_cnt >= aw_dly) i_axi_awready = 1;
          else aw_cnt++;
        end
        i_axi_wready = 0;
        if (o_axi_wvalid && !w_got) begin
          if (w_cnt >= w_dly) i_axi_wready = 1;
          else w_cnt++;
        end
        i_axi_arready = 0;
        if (o_axi_arvalid && !ar_got) begin
          if (ar_cnt >= ar_dly) i_axi_arready = 1;
          else ar_cnt++;
        end
        if (aw_got && w_got && !i_axi_bvalid) begin
          if (b_cnt >= b_dly) begin
            i_axi_bvalid = 1;
            if (mapped(aw_a)) begin
              slave_mem[aw_a[4:2]] = w_d;
              i_axi_bresp = 2'b00;
            end else begin
              i_axi_bresp = 2'b10;
            end
          end else b_cnt++;
        end
        if (ar_got && !i_axi_rvalid) begin
          if (r_cnt >= r_dly) begin
            i_axi_rvalid = 1;
            if (mapped(ar_a)) begin
              i_axi_rdata = slave_mem[ar_a[4:2]];
              i_axi_rresp = 2'b00;
            end else begin
              i_axi_rdata = 32'hDEAD_DEAD;
              i_axi_rresp = 2'b10;
            end
          end else r_cnt++;
        end
        aw_fp = o_axi_awvalid && i_axi_awready;
        if (aw_fp) aw_a = o_axi_awaddr;
        w_fp = o_axi_wvalid && i_axi_wready;
        if (w_fp) w_d = o_axi_wdata;
        ar_fp = o_axi_arvalid && i_axi_arready;
        if (ar_fp) ar_a = o_axi_araddr;
        b_fp = i_axi_bvalid && o_axi_bready;
        r_fp = i_axi_rvalid && o_axi_rready;
      end
    end
  end

  // ---------------- transaction-level reference ----------------
  typedef struct {
    logic        w;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [8];

  task automatic model(input bit wr, input logic [11:0] a,
                       input logic [31:0] d);
    exp_t e;
    e.w = wr;
    e.rdata = '0;
    if (mapped(a)) begin
      e.resp = 2'b00;
      if (wr) ref_mem[a[4:2]] = d;
      else e.rdata = ref_mem[a[4:2]];
    end else begin
      e.resp = 2'b10;
      if (!wr) e.rdata = 32'hDEAD_DEAD;
    end
    exp_q.push_back(e);
  endtask

  // drive a command; returns one negedge after the accept edge
  task automatic send_cmd(input bit wr, input logic [11:0] a,
                          input logic [31:0] d);
    int n = 0;
    i_cmd_valid = 1; i_cmd_write = wr;
    i_cmd_addr = a; i_cmd_wdata = d;
    while (!o_cmd_ready && n < 60) begin
      @(negedge clk); n++;
    end
    chk("cmd_accept_timeout", {63'd0, o_cmd_ready}, 64'd1);
    model(wr, a, d);
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 60) begin
      @(negedge clk); lat++;
    end
    chk("rsp_timeout", {63'd0, o_rsp_valid}, 64'd1);
  endtask

  task automatic finish_rsp(input int hold);
    exp_t e;
    logic        w0;
    logic [1:0]  r0;
    logic [31:0] d0;
    e = exp_q.pop_front();
    w0 = o_rsp_write; r0 = o_rsp_resp; d0 = o_rsp_rdata;
    chk("rsp_write", {63'd0, o_rsp_write}, {63'd0, e.w});
    chk("rsp_resp", {62'd0, o_rsp_resp}, {62'd0, e.resp});
    chk("rsp_rdata", {32'd0, o_rsp_rdata}, {32'd0, e.rdata});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, o_rsp_valid}, 64'd1);
      chk("hold_stable", {29'd0, o_rsp_write, o_rsp_resp, o_rsp_rdata},
          {29'd0, w0, r0, d0});
      chk("hold_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
      chk("hold_no_axi",
          {61'd0, o_axi_awvalid, o_axi_wvalid, o_axi_arvalid}, 64'd0);
    end
    i_rsp_ready = 1;
    @(negedge clk);
    i_rsp_ready = 0;
    chk("post_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
    chk("post_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
  endtask

  logic [11:0] addr_tab [10] = '{12'h000, 12'h004, 12'h008, 12'h00C,
    12'h010, 12'h014, 12'h018, 12'h01C, 12'h020, 12'hFFC};

  initial begin
    int lat;
    bit wr;
    logic [11:0] a;
    logic [31:0] d;
    for (int k = 0; k < 8; k++) ref_mem[k] = '0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    chk("rst_valids", {58'd0, o_rsp_valid, o_axi_awvalid, o_axi_wvalid,
        o_axi_arvalid, o_axi_bready, o_axi_rready}, 64'd0);
    chk("rst_data", {28'd0, o_axi_awaddr, o_axi_wdata, o_rsp_resp,
        o_rsp_write, o_rsp_rdata[0]}, 64'd0);
    chk("rst_rdata", {32'd0, o_rsp_rdata}, 64'd0);
    rst_n = 1;
    @(negedge clk);

    // zero-wait write then read back
    send_cmd(1, 12'h008, 32'h0000_0E83);
    i_cmd_valid = 0;
    chk("wr_aw_w_cyc1", {62'd0, o_axi_awvalid, o_axi_wvalid}, 64'd3);
    chk("wr_awaddr", {52'd0, o_axi_awaddr}, 64'h008);
    chk("wr_wdata", {32'd0, o_axi_wdata}, 64'h0E83);
    wait_rsp(lat);
    chk("wr_latency", 64'(lat), 64'd3);
    finish_rsp(0);
    send_cmd(0, 12'h008, 32'h0);
    i_cmd_valid = 0;
    chk("rd_ar_cyc1", {63'd0, o_axi_arvalid}, 64'd1);
    chk("rd_araddr", {52'd0, o_axi_araddr}, 64'h008);
    wait_rsp(lat);
    chk("rd_latency", 64'(lat), 64'd3);
    finish_rsp(0);

    // awready delayed 3 cycles, wready immediate
    aw_dly = 3;
    send_cmd(1, 12'h010, 32'hA5A5_1234);
    i_cmd_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("dly_wvalid_low", {63'd0, o_axi_wvalid}, 64'd0);
      chk("dly_awvalid_hi", {63'd0, o_axi_awvalid}, 64'd1);
      chk("dly_awaddr", {52'd0, o_axi_awaddr}, 64'h010);
      chk("dly_bready_low", {63'd0, o_axi_bready}, 64'd0);
    end
    @(negedge clk);
    chk("dly_aw_done", {63'd0, o_axi_awvalid}, 64'd0);
    chk("dly_bready_hi", {63'd0, o_axi_bready}, 64'd1);
    wait_rsp(lat);
    finish_rsp(0);
    aw_dly = 0;

    // unmapped read, held response
    send_cmd(0, 12'h01C, 32'h0);
    i_cmd_valid = 0;
    wait_rsp(lat);
    chk("slverr_resp", {62'd0, o_rsp_resp}, 64'd2);
    chk("slverr_rdata", {32'd0, o_rsp_rdata}, 64'hDEAD_DEAD);
    finish_rsp(5);

    // back-to-back with valid held high
    send_cmd(1, 12'h004, 32'h1357_9BDF);
    i_cmd_write = 0;
    i_cmd_addr = 12'h004;
    wait_rsp(lat);
    finish_rsp(0);
    model(0, 12'h004, 32'h0);
    @(negedge clk);
    i_cmd_valid = 0;
    chk("b2b_accepted", {63'd0, o_cmd_ready}, 64'd0);
    chk("b2b_arvalid", {63'd0, o_axi_arvalid}, 64'd1);
    wait_rsp(lat);
    chk("b2b_latency", 64'(lat), 64'd3);
    finish_rsp(0);

    // reset during WR_REQ
    aw_dly = 5;
    i_cmd_valid = 1; i_cmd_write = 1;
    i_cmd_addr = 12'h00C; i_cmd_wdata = 32'hFFFF_0000;
    @(negedge clk);
    i_cmd_valid = 0;
    chk("rst_mid_awvalid", {63'd0, o_axi_awvalid}, 64'd1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valids", {61'd0, o_axi_awvalid, o_axi_wvalid,
        o_axi_arvalid}, 64'd0);
    chk("rst_mid_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    chk("rst_mid_awaddr", {52'd0, o_axi_awaddr}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    aw_dly = 0;
    @(negedge clk);
    chk("rst_rel_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
    send_cmd(0, 12'h00C, 32'h0);
    i_cmd_valid = 0;
    wait_rsp(lat);
    finish_rsp(0);

    // random traffic with random wait states
    for (int i = 0; i < 24; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      a = addr_tab[$urandom_range(0, 9)];
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      send_cmd(wr, a, d);
      i_cmd_valid = 0;
      wait_rsp(lat);
      finish_rsp($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
